// File: rtl/circle_radius_animator.sv
// -----------------------------------------------------------------------------
// circle_radius_animator
// Per-frame animation controller for the circle renderer. Detects frame start
// from the (asynchronous, active-low) vsync, steps the circle radius between
// R_MIN and R_MAX with a pause at each end, and publishes the radius together
// with the ring bounds r^2 - BAND (saturating) and r^2 + BAND.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous reset, active-high
//   i_vsync      vsync from timing generator, active-low, asynchronous
//   i_sel        step select: 00=0, 01=1, 10=2, 11=4 per frame
//   i_freeze     holds radius/FSM/pause; frame counter keeps running
//   o_radius     current radius
//   o_r2_lo      r^2 - BAND, saturating at 0
//   o_r2_hi      r^2 + BAND
//   o_dir        1 = growing (GROW/PAUSE_LO), 0 = shrinking (SHRINK/PAUSE_HI)
//   o_upd        one-cycle strobe: new radius and bounds valid
//   o_frame_cnt  frame counter, wraps 4095 -> 0
//
// FSM states
//   state       | meaning
//   ST_GROW     | radius increases by step each frame
//   ST_PAUSE_HI | radius held at R_MAX for PAUSE_FRAMES frames
//   ST_SHRINK   | radius decreases by step each frame
//   ST_PAUSE_LO | radius held at R_MIN for PAUSE_FRAMES frames
// -----------------------------------------------------------------------------
module circle_radius_animator #(
   parameter int W            = 15,
   parameter int R_MIN        = 20,
   parameter int R_MAX        = 230,
   parameter int R_INIT       = 100,
   parameter int BAND         = 50,
   parameter int PAUSE_FRAMES = 30
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_vsync,
   input  logic [1:0]     i_sel,
   input  logic           i_freeze,
   output logic [W-1:0]   o_radius,
   output logic [2*W-1:0] o_r2_lo,
   output logic [2*W:0]   o_r2_hi,
   output logic           o_dir,
   output logic           o_upd,
   output logic [11:0]    o_frame_cnt
);

   localparam int PW = $clog2(PAUSE_FRAMES + 1);
   localparam logic [2*W-1:0] SQ_INIT = (2*W)'(R_INIT * R_INIT);
   localparam logic [2*W-1:0] BAND_V  = (2*W)'(BAND);

   typedef enum logic [1:0] {ST_GROW, ST_PAUSE_HI, ST_SHRINK, ST_PAUSE_LO} state_t;

   logic           r_vs_s1, r_vs_s2, r_vs_s3;
   logic           w_tick, w_adv;
   logic [11:0]    r_frame_cnt;

   state_t         r_state, w_state_nxt;
   logic [W-1:0]   r_radius, w_radius_nxt;
   logic [PW-1:0]  r_pause, w_pause_nxt;
   logic           r_dir, w_dir_nxt;
   logic [W-1:0]   w_step;
   logic [W:0]     w_sum, w_lo_lim;

   logic           r_v1, r_v2;
   logic [2*W-1:0] r_sq, w_rad_ext, w_r2_lo;

   // Two-FF synchroniser plus one history bit for the falling-edge detect.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vs_s1 <= 1'b1;
         r_vs_s2 <= 1'b1;
         r_vs_s3 <= 1'b1;
      end else begin
         r_vs_s1 <= i_vsync;
         r_vs_s2 <= r_vs_s1;
         r_vs_s3 <= r_vs_s2;
      end
   end

   assign w_tick = r_vs_s3 & ~r_vs_s2;
   assign w_adv  = w_tick & ~i_freeze;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_frame_cnt <= '0;
      else if (w_tick) r_frame_cnt <= r_frame_cnt + 12'd1;
   end

   assign o_frame_cnt = r_frame_cnt;

   always_comb begin
      w_step = '0;
      case (i_sel)
         2'b01:   w_step = W'(1);
         2'b10:   w_step = W'(2);
         2'b11:   w_step = W'(4);
         default: w_step = '0;
      endcase
   end

   // One extra bit so neither the sum nor the lower-limit compare can wrap.
   assign w_sum    = {1'b0, r_radius} + {1'b0, w_step};
   assign w_lo_lim = (W+1)'(R_MIN) + {1'b0, w_step};

   always_comb begin
      w_state_nxt  = r_state;
      w_radius_nxt = r_radius;
      w_pause_nxt  = r_pause;
      case (r_state)
         ST_GROW: begin
            if (w_sum >= (W+1)'(R_MAX)) begin
               w_radius_nxt = W'(R_MAX);
               w_pause_nxt  = PW'(PAUSE_FRAMES);
               w_state_nxt  = ST_PAUSE_HI;
            end else begin
               w_radius_nxt = w_sum[W-1:0];
            end
         end
         ST_PAUSE_HI: begin
            w_pause_nxt = r_pause - PW'(1);
            if (r_pause == PW'(1)) w_state_nxt = ST_SHRINK;
         end
         ST_SHRINK: begin
            if ({1'b0, r_radius} <= w_lo_lim) begin
               w_radius_nxt = W'(R_MIN);
               w_pause_nxt  = PW'(PAUSE_FRAMES);
               w_state_nxt  = ST_PAUSE_LO;
            end else begin
               w_radius_nxt = r_radius - w_step;
            end
         end
         ST_PAUSE_LO: begin
            w_pause_nxt = r_pause - PW'(1);
            if (r_pause == PW'(1)) w_state_nxt = ST_GROW;
         end
         default: w_state_nxt = ST_GROW;
      endcase
      w_dir_nxt = (w_state_nxt == ST_GROW) || (w_state_nxt == ST_PAUSE_LO);
   end

   // Stage 1: radius/state register, advanced only on non-frozen ticks.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_GROW;
         r_radius <= W'(R_INIT);
         r_pause  <= '0;
         r_dir    <= 1'b1;
         r_v1     <= 1'b0;
      end else begin
         r_v1 <= w_adv;
         if (w_adv) begin
            r_state  <= w_state_nxt;
            r_radius <= w_radius_nxt;
            r_pause  <= w_pause_nxt;
            r_dir    <= w_dir_nxt;
         end
      end
   end

   // Stage 2: square. Stage 1 holds still for the following cycles because
   // ticks are always several clocks apart, so stage 3 can read it directly.
   assign w_rad_ext = {{W{1'b0}}, r_radius};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sq <= SQ_INIT;
         r_v2 <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) r_sq <= w_rad_ext * w_rad_ext;
      end
   end

   assign w_r2_lo = (r_sq >= BAND_V) ? (r_sq - BAND_V) : '0;

   // Stage 3: publish everything together with the strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_radius <= W'(R_INIT);
         o_r2_lo  <= SQ_INIT - BAND_V;
         o_r2_hi  <= {1'b0, SQ_INIT} + {1'b0, BAND_V};
         o_dir    <= 1'b1;
         o_upd    <= 1'b0;
      end else begin
         o_upd <= r_v2;
         if (r_v2) begin
            o_radius <= r_radius;
            o_dir    <= r_dir;
            o_r2_lo  <= w_r2_lo;
            o_r2_hi  <= {1'b0, r_sq} + {1'b0, BAND_V};
         end
      end
   end

endmodule
